// File: rtl/ps2_scan_pkg.sv
// ps2_scan_pkg: shared constants and types for the PS/2 Set-2 scancode
// decoders. Holds the prefix bytes, the digit make codes for the number row
// and the numpad, the decoder FSM state type and the Pause sequence length.
package ps2_scan_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  // Player 0: number row make codes
  localparam logic [7:0] SC_P0_0 = 8'h45;
  localparam logic [7:0] SC_P0_1 = 8'h16;
  localparam logic [7:0] SC_P0_2 = 8'h1E;
  localparam logic [7:0] SC_P0_3 = 8'h26;
  localparam logic [7:0] SC_P0_4 = 8'h25;
  localparam logic [7:0] SC_P0_5 = 8'h2E;
  localparam logic [7:0] SC_P0_6 = 8'h36;
  localparam logic [7:0] SC_P0_7 = 8'h3D;
  localparam logic [7:0] SC_P0_8 = 8'h3E;
  localparam logic [7:0] SC_P0_9 = 8'h46;

  // Player 1: numpad make codes
  localparam logic [7:0] SC_P1_0 = 8'h70;
  localparam logic [7:0] SC_P1_1 = 8'h69;
  localparam logic [7:0] SC_P1_2 = 8'h72;
  localparam logic [7:0] SC_P1_3 = 8'h7A;
  localparam logic [7:0] SC_P1_4 = 8'h6B;
  localparam logic [7:0] SC_P1_5 = 8'h73;
  localparam logic [7:0] SC_P1_6 = 8'h74;
  localparam logic [7:0] SC_P1_7 = 8'h6C;
  localparam logic [7:0] SC_P1_8 = 8'h75;
  localparam logic [7:0] SC_P1_9 = 8'h7D;

  // Bytes that follow E1 in the Pause make sequence (E1 14 77 E1 F0 14 F0 77)
  localparam logic [2:0] PAUSE_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK,
    ST_PAUSE
  } ps2_state_e;

endpackage

// File: rtl/ps2_digit_lut.sv
// ps2_digit_lut: combinational scancode to digit lookup.
// Ports:
//   key      in  8  raw Set-2 scancode byte
//   is_digit out 1  byte is one of the twenty digit make codes
//   player   out 1  0 = number row, 1 = numpad (0 when not a digit)
//   num      out 4  digit value 0-9 (0 when not a digit)
module ps2_digit_lut
  import ps2_scan_pkg::*;
(
  input  logic [7:0] key,
  output logic       is_digit,
  output logic       player,
  output logic [3:0] num
);

  always_comb begin
    is_digit = 1'b1;
    player   = 1'b0;
    num      = 4'd0;
    case (key)
      SC_P0_0: num = 4'd0;
      SC_P0_1: num = 4'd1;
      SC_P0_2: num = 4'd2;
      SC_P0_3: num = 4'd3;
      SC_P0_4: num = 4'd4;
      SC_P0_5: num = 4'd5;
      SC_P0_6: num = 4'd6;
      SC_P0_7: num = 4'd7;
      SC_P0_8: num = 4'd8;
      SC_P0_9: num = 4'd9;
      SC_P1_0: begin player = 1'b1; num = 4'd0; end
      SC_P1_1: begin player = 1'b1; num = 4'd1; end
      SC_P1_2: begin player = 1'b1; num = 4'd2; end
      SC_P1_3: begin player = 1'b1; num = 4'd3; end
      SC_P1_4: begin player = 1'b1; num = 4'd4; end
      SC_P1_5: begin player = 1'b1; num = 4'd5; end
      SC_P1_6: begin player = 1'b1; num = 4'd6; end
      SC_P1_7: begin player = 1'b1; num = 4'd7; end
      SC_P1_8: begin player = 1'b1; num = 4'd8; end
      SC_P1_9: begin player = 1'b1; num = 4'd9; end
      default: is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns the raw PS/2 Set-2 byte stream into clean digit
// press events. Tracks F0/E0/E1 prefixes, drops extended keys and releases,
// optionally filters typematic repeat, and abandons stale prefixes.
// Ports:
//   clk         in  1   system clock
//   reset_n     in  1   synchronous active-low reset
//   key         in  8   scancode byte
//   key_valid   in  1   one-cycle strobe per byte
//   num         out 4   last pressed digit (held between events)
//   player      out 1   0 = number row, 1 = numpad (held between events)
//   input_valid out 1   one-cycle press pulse, one cycle after the make byte
//   held        out 20  held digits: [9:0] player 0, [19:10] player 1
//   seq_error   out 1   one-cycle pulse when a prefix sequence times out
module ps2_key_decoder
  import ps2_scan_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 2000000,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  key,
  input  logic        key_valid,
  output logic [3:0]  num,
  output logic        player,
  output logic        input_valid,
  output logic [19:0] held,
  output logic        seq_error
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e        state_reg, state_next;
  logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic [2:0]        pause_cnt_reg, pause_cnt_next;
  logic [19:0]       held_reg, held_next;
  logic [3:0]        num_reg, num_next;
  logic              player_reg, player_next;
  logic              fire_reg, fire_next;
  logic              seq_err_reg, seq_err_next;

  logic              lut_is_digit;
  logic              lut_player;
  logic [3:0]        lut_num;
  logic [4:0]        lut_idx;
  logic [19:0]       digit_mask;

  ps2_digit_lut u_lut (
    .key      (key),
    .is_digit (lut_is_digit),
    .player   (lut_player),
    .num      (lut_num)
  );

  // Position of the current byte in the held mask; the mask is all-zero
  // for non-digit bytes so it can be OR-ed / AND-ed in unconditionally.
  assign lut_idx = lut_player ? (5'd10 + {1'b0, lut_num}) : {1'b0, lut_num};

  genvar gi;
  generate
    for (gi = 0; gi < 20; gi++) begin : g_mask
      assign digit_mask[gi] = lut_is_digit && (lut_idx == 5'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      tmo_cnt_reg   <= '0;
      pause_cnt_reg <= '0;
      held_reg      <= '0;
      num_reg       <= '0;
      player_reg    <= 1'b0;
      fire_reg      <= 1'b0;
      seq_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      pause_cnt_reg <= pause_cnt_next;
      held_reg      <= held_next;
      num_reg       <= num_next;
      player_reg    <= player_next;
      fire_reg      <= fire_next;
      seq_err_reg   <= seq_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    tmo_cnt_next   = '0;
    pause_cnt_next = pause_cnt_reg;
    held_next      = held_reg;
    num_next       = num_reg;
    player_next    = player_reg;
    fire_next      = 1'b0;
    seq_err_next   = 1'b0;

    if (key_valid) begin
      // A byte always beats a coincident timeout expiry.
      case (state_reg)
        ST_IDLE: begin
          if (key == SC_BRK) begin
            state_next = ST_BRK;
          end else if (key == SC_EXT) begin
            state_next = ST_EXT;
          end else if (key == SC_PAUSE) begin
            state_next     = ST_PAUSE;
            pause_cnt_next = PAUSE_LEN;
          end else if (lut_is_digit) begin
            if (!((SUPPRESS_REPEAT != 0) && ((held_reg & digit_mask) != '0))) begin
              held_next   = held_reg | digit_mask;
              fire_next   = 1'b1;
              num_next    = lut_num;
              player_next = lut_player;
            end
          end
        end
        ST_BRK: begin
          held_next  = held_reg & ~digit_mask;
          state_next = ST_IDLE;
        end
        ST_EXT: begin
          state_next = (key == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_EXT_BRK: begin
          state_next = ST_IDLE;
        end
        ST_PAUSE: begin
          pause_cnt_next = pause_cnt_reg - 3'd1;
          // <= 1 also recovers from a zero count instead of wrapping.
          if (pause_cnt_reg <= 3'd1) begin
            pause_cnt_next = '0;
            state_next     = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (state_reg != ST_IDLE) begin
      if (tmo_cnt_reg >= TMO_LAST) begin
        state_next   = ST_IDLE;
        seq_err_next = 1'b1;
      end else begin
        tmo_cnt_next = tmo_cnt_reg + 1'b1;
      end
    end
  end

  assign num         = num_reg;
  assign player      = player_reg;
  assign input_valid = fire_reg;
  assign held        = held_reg;
  assign seq_error   = seq_err_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder. Two instances see the same stimulus:
// dut_a filters repeats, dut_b fires on every make byte. Expected presses
// are queued by the stimulus; monitors compare on every input_valid pulse.
module tb_ps2_key_decoder;

  localparam int TMO = 16;

  typedef struct {
    logic [3:0] num;
    logic       player;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  key;
  logic        key_valid;

  logic [3:0]  num_a, num_b;
  logic        player_a, player_b;
  logic        iv_a, iv_b;
  logic [19:0] held_a, held_b;
  logic        se_a, se_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   seq_cnt_a = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .key(key), .key_valid(key_valid),
    .num(num_a), .player(player_a), .input_valid(iv_a), .held(held_a),
    .seq_error(se_a)
  );

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .key(key), .key_valid(key_valid),
    .num(num_b), .player(player_b), .input_valid(iv_b), .held(held_b),
    .seq_error(se_b)
  );

  // Monitors: pop and compare on every press pulse.
  always @(negedge clk) begin
    if (se_a) seq_cnt_a++;
    if (iv_a) begin
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL press_a unexpected pulse num=%0d player=%0d cyc=%0d", num_a, player_a, cyc);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        if (num_a !== e.num || player_a !== e.player || cyc != e.cyc) begin
          failures++;
          $display("FAIL press_a got num=%0d player=%0d cyc=%0d want num=%0d player=%0d cyc=%0d",
                   num_a, player_a, cyc, e.num, e.player, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (iv_b) begin
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL press_b unexpected pulse num=%0d player=%0d cyc=%0d", num_b, player_b, cyc);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        if (num_b !== e.num || player_b !== e.player || cyc != e.cyc) begin
          failures++;
          $display("FAIL press_b got num=%0d player=%0d cyc=%0d want num=%0d player=%0d cyc=%0d",
                   num_b, player_b, cyc, e.num, e.player, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // One byte strobe; caller is at posedge+1. Expected presses are queued
  // with the cycle at which input_valid must be seen.
  task automatic send(input logic [7:0] b, input bit fa, input bit fb,
                      input logic [3:0] n, input logic p);
    key       = b;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    if (fa) q_a.push_back('{num: n, player: p, cyc: cyc});
    if (fb) q_b.push_back('{num: n, player: p, cyc: cyc});
    $display("tx key=%h expect_a=%0d expect_b=%0d num=%0d player=%0d", b, fa, fb, n, p);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    key       = 8'h00;
    key_valid = 1'b0;
    idle(3);
    check("rst_num", 32'(num_a), 32'd0);
    check("rst_player", 32'(player_a), 32'd0);
    check("rst_input_valid", 32'(iv_a), 32'd0);
    check("rst_held", 32'(held_a), 32'd0);
    check("rst_seq_error", 32'(se_a), 32'd0);
    reset_n = 1'b1;
    idle(1);

    // Number row 1: press and release
    send(8'h16, 1, 1, 4'd1, 1'b0);
    check("held_p0_1_set", 32'(held_a), 32'h00002);
    send(8'hF0, 0, 0, 4'd0, 1'b0);
    send(8'h16, 0, 0, 4'd0, 1'b0);
    check("held_p0_1_clr", 32'(held_a), 32'h00000);

    // Numpad 0, then Insert (E0 70) must not fire nor touch held
    send(8'h70, 1, 1, 4'd0, 1'b1);
    check("held_p1_0_set", 32'(held_a), 32'h00400);
    send(8'hE0, 0, 0, 4'd0, 1'b0);
    send(8'h70, 0, 0, 4'd0, 1'b0);
    check("held_after_insert", 32'(held_a), 32'h00400);
    send(8'hF0, 0, 0, 4'd0, 1'b0);
    send(8'h70, 0, 0, 4'd0, 1'b0);
    check("held_p1_0_clr", 32'(held_a), 32'h00000);

    // Typematic numpad 9 (back-to-back strobes)
    send(8'h7D, 1, 1, 4'd9, 1'b1);
    send(8'h7D, 0, 1, 4'd9, 1'b1);
    send(8'h7D, 0, 1, 4'd9, 1'b1);
    check("held_p1_9_rep", 32'(held_a), 32'h80000);
    send(8'hF0, 0, 0, 4'd0, 1'b0);
    send(8'h7D, 0, 0, 4'd0, 1'b0);
    check("held_p1_9_clr", 32'(held_b), 32'h00000);
    send(8'h7D, 1, 1, 4'd9, 1'b1);
    send(8'hF0, 0, 0, 4'd0, 1'b0);
    send(8'h7D, 0, 0, 4'd0, 1'b0);

    // Pause sequence, then number row 0
    send(8'hE1, 0, 0, 4'd0, 1'b0);
    send(8'h14, 0, 0, 4'd0, 1'b0);
    send(8'h77, 0, 0, 4'd0, 1'b0);
    send(8'hE1, 0, 0, 4'd0, 1'b0);
    send(8'hF0, 0, 0, 4'd0, 1'b0);
    send(8'h14, 0, 0, 4'd0, 1'b0);
    send(8'hF0, 0, 0, 4'd0, 1'b0);
    send(8'h77, 0, 0, 4'd0, 1'b0);
    check("held_after_pause", 32'(held_a), 32'h00000);
    send(8'h45, 1, 1, 4'd0, 1'b0);
    check("held_p0_0_set", 32'(held_a), 32'h00001);

    // Stale E0 times out, then number row 3 fires
    send(8'hE0, 0, 0, 4'd0, 1'b0);
    idle(TMO + 4);
    check("seq_error_e0", 32'(seq_cnt_a), 32'd1);
    send(8'h26, 1, 1, 4'd3, 1'b0);
    check("held_p0_3_set", 32'(held_a), 32'h00009);
    send(8'hF0, 0, 0, 4'd0, 1'b0);
    send(8'h26, 0, 0, 4'd0, 1'b0);
    check("held_p0_3_clr", 32'(held_a), 32'h00001);

    // Stale F0 times out without releasing anything, then 26 fires
    send(8'hF0, 0, 0, 4'd0, 1'b0);
    idle(TMO + 4);
    check("seq_error_f0", 32'(seq_cnt_a), 32'd2);
    check("held_after_f0_tmo", 32'(held_a), 32'h00001);
    send(8'h26, 1, 1, 4'd3, 1'b0);
    check("held_p0_3_again", 32'(held_a), 32'h00009);

    // Byte on the expiry cycle wins: 70 is taken as E0 70, no press
    send(8'hE0, 0, 0, 4'd0, 1'b0);
    idle(TMO - 1);
    send(8'h70, 0, 0, 4'd0, 1'b0);
    idle(2);
    check("seq_error_boundary", 32'(seq_cnt_a), 32'd2);
    check("held_boundary", 32'(held_a), 32'h00009);

    // Reset in the middle of a break sequence
    send(8'h1E, 1, 1, 4'd2, 1'b0);
    check("held_p0_2_set", 32'(held_a), 32'h0000D);
    send(8'hF0, 0, 0, 4'd0, 1'b0);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    check("held_after_reset", 32'(held_a), 32'h00000);
    send(8'h1E, 1, 1, 4'd2, 1'b0);
    check("held_p0_2_after_reset", 32'(held_a), 32'h00004);

    idle(3);
    check("queue_a_drained", 32'(q_a.size()), 32'd0);
    check("queue_b_drained", 32'(q_b.size()), 32'd0);
    check("seq_error_total", 32'(seq_cnt_a), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits between the PS/2 byte receiver (get_key) and the game controller. Consumes the raw Set-2 scancode byte stream.
- Tracks the E0, F0 and E1 prefix sequences and filters typematic auto-repeat.
- Emits one clean, single-cycle press event per physical key-down: a digit 0-9 plus a player ID.
- Replaces the purely combinational key2input mapping, so that extended keys (arrows, Insert, Home, etc.) and key releases never score as presses.

Parameters:
- TIMEOUT_CYCLES, default 2000000: idle cycles (20 ms at 100 MHz) after which a half-received prefix sequence is abandoned.
- SUPPRESS_REPEAT, default 1: 1 = a key must be released before it can fire again; 0 = every make byte fires.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset_n  input  1  synchronous, active-low reset.
- key  input  8  scancode byte from get_key.
- key_valid  input  1  one-cycle strobe, one per received byte.
- num  output  4  decoded digit 0-9; holds its value between events.
- player  output  1  0 = number row, 1 = numpad; holds between events.
- input_valid  output  1  one-cycle press pulse.
- held  output  20  currently-held mask: bits [9:0] = player 0 digits, bits [19:10] = player 1 digits.
- seq_error  output  1  one-cycle pulse when a prefix sequence times out.

Behaviour:
- Reset (reset_n low at a clk edge):
  - num=0, player=0, input_valid=0, held=0, seq_error=0.
  - FSM goes to IDLE; timeout counter and pause counter cleared.
  - Reset takes priority over a coincident key_valid; any partially received sequence is discarded.
- Digit map (un-prefixed bytes only):
  - Player 0 (number row): 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9, 45→0.
  - Player 1 (numpad): 69→1, 72→2, 7A→3, 6B→4, 73→5, 74→6, 6C→7, 75→8, 7D→9, 70→0.
  - Every other byte is a "non-digit".
- FSM states: IDLE, BRK, EXT, EXT_BRK, PAUSE. Transitions happen only on key_valid.
- IDLE:
  - F0 → BRK.
  - E0 → EXT.
  - E1 → PAUSE, pause counter loaded with 7.
  - Digit code: if SUPPRESS_REPEAT=1 and its held bit is already 1, ignore it. Otherwise set the held bit and fire.
  - Non-digit bytes (including AA, FA, FE, EE) are ignored.
- BRK: on the next byte, clear the held bit if that byte is a digit code, then → IDLE. No event fires.
- EXT:
  - F0 → EXT_BRK.
  - Any other byte → IDLE with no event. E0 70 (Insert), E0 69 (End), the E0 arrow keys, etc. must never fire.
- EXT_BRK: next byte → IDLE. No event, and held is not touched.
- PAUSE: each byte decrements the pause counter; when it reaches 0 → IDLE. No events fire during PAUSE.
- Fire timing:
  - On the clk edge that samples the make byte with key_valid=1, register num and player.
  - input_valid is high for exactly the next cycle, i.e. 1-cycle latency from the key_valid cycle.
  - Back-to-back key_valid strobes on consecutive cycles must each be processed; input_valid may then be high on consecutive cycles.
- Timeout:
  - While in BRK, EXT, EXT_BRK or PAUSE, a counter increments each cycle with no key_valid and is reset on every key_valid.
  - On reaching TIMEOUT_CYCLES-1: → IDLE, pulse seq_error for 1 cycle, leave held unchanged.
  - The counter is held at 0 while in IDLE.
  - The counter is sized clog2(TIMEOUT_CYCLES) bits and saturates (no wrap).
- Simultaneous events: a timeout expiry and a key_valid in the same cycle — key_valid wins, the byte is processed in the current state, and seq_error does not fire.
- held reflects the state after the current byte, one cycle after key_valid.

Decomposition:
- Package ps2_scan_pkg holds:
  - scancode constants (SC_BRK=F0, SC_EXT=E0, SC_PAUSE=E1, the digit codes);
  - the FSM state enum;
  - the pause length constant (7).
- Sub-module ps2_digit_lut: combinational, key[7:0] → {is_digit, player, num[3:0]}. It is shared with any later decoder.

Test Plan:
- Reset then bytes 16, F0, 16 → exactly one input_valid, one cycle after the 16 strobe, with num=1, player=0. held[1] goes 1, then back to 0 after F0 16.
- Bytes 70 then E0 70 → first byte fires num=0, player=1. The E0 70 produces no pulse. Then F0 70 clears held[10].
- Typematic: 7D, 7D, 7D, F0 7D, 7D → exactly two pulses (first and last 7D), each num=9, player=1. With SUPPRESS_REPEAT=0 → four pulses.
- Pause sequence E1 14 77 E1 F0 14 F0 77 followed by 45 → no pulse during the sequence. Then one pulse num=0, player=0. FSM is back in IDLE.
- E0 then TIMEOUT_CYCLES idle cycles, then 26 → seq_error pulses once, then 26 fires num=3, player=0. Also: F0 alone then timeout → 26 still fires.
- reset_n asserted low for 1 cycle between F0 and 1E, with held[2]=1 → held=0 and FSM=IDLE. The following 1E then fires num=2.
